// File: rtl/fifo_rd_pkg.sv
// Shared types and constants for the FIFO read-side stream adapter.
// The local buffer is three entries deep, so its pointers wrap modulo 3.
package fifo_rd_pkg;

  localparam int FIFO_RD_DEPTH  = 3;
  localparam int DEFAULT_DATA_W = 4;

  typedef logic [1:0] occ_t;
  typedef logic [1:0] ptr_t;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(FIFO_RD_DEPTH - 1)) ? ptr_t'(0) : p + ptr_t'(1);
  endfunction

endpackage

// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus valid/ready output stream, seen from the adapter (master)
// and from its environment (slave: the FIFO and the downstream consumer).
interface fifo_rd_stream_if
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
);

  logic              buf_empty;
  logic              rd_en;
  logic [DATA_W-1:0] dout;
  logic              m_valid;
  logic [DATA_W-1:0] m_data;
  logic              m_ready;

  modport master (
    input  buf_empty, dout, m_ready,
    output rd_en, m_valid, m_data
  );

  modport slave (
    output buf_empty, dout, m_ready,
    input  rd_en, m_valid, m_data
  );

endinterface

// File: rtl/fifo_rd_skid.sv
// Three-entry register buffer with modulo-3 head/tail pointers.
// Push and pop may happen on the same edge; order is always preserved.
module fifo_rd_skid
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] din,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output occ_t              occ
);

  logic [DATA_W-1:0] mem [FIFO_RD_DEPTH];
  ptr_t              wr_ptr;
  ptr_t              rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: the entries are cleared so the head reads zero after reset.
      for (int i = 0; i < FIFO_RD_DEPTH; i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      occ    <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= din;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({push, pop})
        2'b10:   occ <= occ + occ_t'(1);
        2'b01:   occ <= occ - occ_t'(1);
        default: occ <= occ;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fifo_rd_stream.sv
// Drains a synchronous FIFO into a valid/ready stream at one word per cycle.
// rd_en is credit-based on registered state, so m_ready never reaches it.
module fifo_rd_stream
  import fifo_rd_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  fifo_rd_stream_if.master  bus,
  output occ_t              occ,
  output logic [CNT_W-1:0]  rd_cnt
);

  logic       inflight;
  logic       pop;
  logic [2:0] credit_used;

  // A word already requested from the FIFO holds a slot just like a buffered one.
  assign credit_used = {1'b0, occ} + {2'b00, inflight};
  assign bus.rd_en   = !rst && !bus.buf_empty && (credit_used < 3'(FIFO_RD_DEPTH));
  assign bus.m_valid = !rst && (occ != '0);
  assign pop         = bus.m_valid && bus.m_ready;

  fifo_rd_skid #(.DATA_W(DATA_W)) u_skid (
    .clk  (clk),
    .rst  (rst),
    .push (inflight),
    .din  (bus.dout),
    .pop  (pop),
    .head (bus.m_data),
    .occ  (occ)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      rd_cnt   <= '0;
    end else begin
      // NOTE: non-blocking, so the pointers and counters all see pre-edge values.
      inflight <= bus.rd_en;
      if (pop) rd_cnt <= rd_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Self-checking bench: a queue-based FIFO model feeds the adapter and a
// scoreboard of written words is compared against every output handshake.
module tb_fifo_rd_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] occ;
  logic [3:0] rd_cnt;

  always #5 clk = ~clk;

  fifo_rd_stream_if #(.DATA_W(4)) bus ();

  fifo_rd_stream #(.DATA_W(4), .CNT_W(4)) dut (
    .clk    (clk),
    .rst    (rst),
    .bus    (bus),
    .occ    (occ),
    .rd_cnt (rd_cnt)
  );

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [3:0] fq[$];
  logic [3:0] sb[$];
  int         cyc = 0;
  int         rd_pulses, n_beats, first_re, first_mv, first_beat, last_beat;
  logic       prev_stall;
  logic [3:0] prev_data;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic clear_stats();
    rd_pulses  = 0;
    n_beats    = 0;
    first_re   = -1;
    first_mv   = -1;
    first_beat = -1;
    last_beat  = -1;
  endtask

  task automatic push_words(input int start, input int n);
    for (int i = 0; i < n; i++) begin
      fq.push_back(4'(start + i));
      sb.push_back(4'(start + i));
    end
  endtask

  // One clock cycle: drive inputs, sample just after, model the FIFO at the edge.
  task automatic cycle(input logic rdy);
    logic       re, hs;
    logic [3:0] d;
    bus.m_ready   = rdy;
    bus.buf_empty = (fq.size() == 0);
    #1;
    re = bus.rd_en;
    hs = bus.m_valid && rdy;
    d  = bus.m_data;
    if (prev_stall) begin
      check("stall_valid", 32'(bus.m_valid), 32'd1);
      check("stall_data", 32'(d), 32'(prev_data));
    end
    prev_stall = bus.m_valid && !rdy;
    prev_data  = d;
    if (re) begin
      rd_pulses++;
      if (first_re < 0) first_re = cyc;
    end
    if (bus.m_valid && first_mv < 0) first_mv = cyc;
    if (hs) begin
      n_beats++;
      if (first_beat < 0) first_beat = cyc;
      last_beat = cyc;
      if (sb.size() == 0) check("beat_unexpected", 32'(sb.size()), 32'd1);
      else                check("beat_data", 32'(d), 32'(sb.pop_front()));
    end
    @(posedge clk);
    #1;
    if (re) begin
      if (fq.size() == 0) check("fifo_underflow", 32'(fq.size()), 32'd1);
      else                bus.dout = fq.pop_front();
    end else begin
      bus.dout = 4'($urandom);
    end
    cyc++;
  endtask

  task automatic drain(input bit toggle, input string tag);
    int n = 0;
    while (sb.size() != 0 && n < 200) begin
      cycle(toggle ? 1'(n % 2) : 1'b1);
      n++;
    end
    cycle(1'b1);
    cycle(1'b1);
    check({tag, "_drained"}, 32'(sb.size()), 32'd0);
    check({tag, "_idle_valid"}, 32'(bus.m_valid), 32'd0);
  endtask

  task automatic do_reset();
    rst           = 1'b1;
    bus.m_ready   = 1'b0;
    bus.buf_empty = (fq.size() == 0);
    #1;
    check("rst_rd_en", 32'(bus.rd_en), 32'd0);
    check("rst_m_valid", 32'(bus.m_valid), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.delete();
    sb.delete();
    bus.dout      = 4'($urandom);
    bus.buf_empty = 1'b1;
    prev_stall    = 1'b0;
    #1;
    check("post_rst_m_valid", 32'(bus.m_valid), 32'd0);
    check("post_rst_m_data", 32'(bus.m_data), 32'd0);
    check("post_rst_occ", 32'(occ), 32'd0);
    check("post_rst_rd_cnt", 32'(rd_cnt), 32'd0);
    check("post_rst_rd_en", 32'(bus.rd_en), 32'd0);
    clear_stats();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    bus.m_ready = 1'b0;
    bus.dout    = '0;
    prev_stall  = 1'b0;
    prev_data   = '0;
    clear_stats();
    do_reset();

    // Streaming at full rate.
    push_words(0, 9);
    drain(1'b0, "s1");
    check("s1_latency", 32'(first_mv - first_re), 32'd2);
    check("s1_contiguous", 32'(last_beat - first_beat), 32'd8);
    check("s1_beats", 32'(n_beats), 32'd9);
    check("s1_rd_cnt", 32'(rd_cnt), 32'd9);

    // Back-pressure from empty: buffer fills to three and reads stop.
    do_reset();
    push_words(0, 9);
    for (int i = 0; i < 10; i++) cycle(1'b0);
    check("s2_rd_pulses", 32'(rd_pulses), 32'd3);
    check("s2_occ", 32'(occ), 32'd3);
    check("s2_fifo_left", 32'(fq.size()), 32'd6);
    check("s2_rd_en_low", 32'(bus.rd_en), 32'd0);
    clear_stats();
    drain(1'b0, "s2");
    check("s2_contiguous", 32'(last_beat - first_beat), 32'd8);
    check("s2_rd_cnt", 32'(rd_cnt), 32'd9);

    // m_ready toggling every cycle.
    do_reset();
    push_words(0, 9);
    drain(1'b1, "s3");
    check("s3_beats", 32'(n_beats), 32'd9);
    check("s3_rd_cnt", 32'(rd_cnt), 32'd9);

    // Reset in the middle of a stream.
    do_reset();
    push_words(0, 9);
    for (int i = 0; i < 40 && n_beats < 4; i++) cycle(1'b1);
    check("s4_pre_beats", 32'(n_beats), 32'd4);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1);
    check("s4_no_stale", 32'(n_beats), 32'd0);
    push_words(10, 3);
    drain(1'b0, "s4");
    check("s4_beats", 32'(n_beats), 32'd3);
    check("s4_rd_cnt", 32'(rd_cnt), 32'd3);

    // rd_cnt wraps at 16 with CNT_W = 4.
    do_reset();
    push_words(0, 9);
    drain(1'b0, "s5a");
    push_words(9, 8);
    drain(1'b0, "s5b");
    check("s5_beats", 32'(n_beats), 32'd17);
    check("s5_rd_cnt_wrap", 32'(rd_cnt), 32'd1);

    // Single-word transfers walk the pointers through their wrap.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      clear_stats();
      push_words(5 + 3 * k, 1);
      drain(1'b0, "s6");
      check("s6_rd_pulses", 32'(rd_pulses), 32'd1);
      check("s6_beats", 32'(n_beats), 32'd1);
    end
    check("s6_rd_cnt", 32'(rd_cnt), 32'd4);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
